// File: rtl/song_sequencer_pkg.sv
// Shared widths, FSM encoding and song contents for the song sequencer.
// Song data is a constant table so the ROM builds without an external init file.
package song_sequencer_pkg;

   localparam int unsigned NoteW = 6;
   localparam int unsigned DurW  = 6;
   localparam int unsigned SongW = 2;
   localparam int unsigned IdxW  = 5;
   localparam int unsigned AddrW = SongW + IdxW;
   localparam int unsigned WordW = NoteW + DurW;

   localparam logic [DurW-1:0] EndMarker = '0;

   typedef enum logic [2:0] {
      StPaused,
      StFetch,
      StWait,
      StLoad,
      StPlaying
   } state_e;

   // Returns {note, duration} for ROM address {song, idx}.
   function automatic logic [WordW-1:0] song_word(input logic [AddrW-1:0] addr);
      logic [SongW-1:0] s;
      logic [IdxW-1:0]  i;
      logic [NoteW-1:0] n;
      logic [DurW-1:0]  d;
      s = addr[AddrW-1:IdxW];
      i = addr[IdxW-1:0];
      n = '0;
      d = EndMarker;
      case (s)
         2'd0: begin
            if (i == 5'd0) begin n = 6'd12; d = 6'd10; end
            else if (i == 5'd1) begin n = 6'd20; d = 6'd5; end
         end
         2'd1: begin
            if (i == 5'd0) begin n = 6'd33; d = 6'd7; end
            else if (i == 5'd1) begin n = 6'd40; d = 6'd2; end
         end
         // Full-length song: every entry valid, so it ends by index wrap.
         2'd2: begin
            n = NoteW'(i) + NoteW'(30);
            d = DurW'(i) + DurW'(1);
         end
         default: begin
            if (i == 5'd0) begin n = 6'd5; d = 6'd3; end
            else if (i == 5'd1) begin n = 6'd6; d = 6'd4; end
            else if (i == 5'd2) begin n = 6'd7; d = 6'd5; end
         end
      endcase
      return {n, d};
   endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// UI / note-player side signals of the song sequencer.
interface song_sequencer_if;
   import song_sequencer_pkg::*;

   logic             play;
   logic [SongW-1:0] song;
   logic             note_done;
   logic [NoteW-1:0] note;
   logic [DurW-1:0]  duration;
   logic             new_note;
   logic             song_done;

   modport slave (
      input  play, song, note_done,
      output note, duration, new_note, song_done
   );

   modport master (
      output play, song, note_done,
      input  note, duration, new_note, song_done
   );

endinterface

// File: rtl/song_sequencer_rom.sv
// Song ROM with one cycle of registered read latency.
module song_sequencer_rom
   import song_sequencer_pkg::*;
(
   input  logic             clk_i,
   input  logic [AddrW-1:0] addr_i,
   output logic [WordW-1:0] data_o
);

   logic [WordW-1:0] data_q;

   always_ff @(posedge clk_i) begin
      data_q <= song_word(addr_i);
   end

   assign data_o = data_q;

endmodule

// File: rtl/song_sequencer.sv
// Walks the song ROM and hands (note, duration) pairs to the note player.
// Define SONG_SEQ_LOOP_EN to repeat a song forever instead of stopping at its end.
module song_sequencer
   import song_sequencer_pkg::*;
(
   input  logic         clk_i,
   input  logic         reset_ni,
   song_sequencer_if.slave bus_io
);

   state_e           state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [SongW-1:0] cur_song_q, cur_song_d;
   logic [NoteW-1:0] note_q, note_d;
   logic [DurW-1:0]  dur_q, dur_d;
   logic             song_done_q, song_done_d;

   logic [WordW-1:0] rom_data;
   logic [NoteW-1:0] rom_note;
   logic [DurW-1:0]  rom_dur;
   logic             song_chg;
   logic             end_of_song;

   song_sequencer_rom u_rom (
      .clk_i  (clk_i),
      .addr_i ({cur_song_q, idx_q}),
      .data_o (rom_data)
   );

   assign {rom_note, rom_dur} = rom_data;
   assign song_chg = (bus_io.song != cur_song_q);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cur_song_d  = cur_song_q;
      note_d      = note_q;
      dur_d       = dur_q;
      end_of_song = 1'b0;
`ifdef SONG_SEQ_LOOP_EN
      song_done_d = 1'b0;
`else
      song_done_d = song_done_q;
`endif

      unique case (state_q)
         StPaused:  if (bus_io.play && !song_done_q) state_d = StFetch;
         StFetch:   state_d = StWait;
         StWait: begin
            if (rom_dur == EndMarker) begin
               end_of_song = 1'b1;
            end else begin
               note_d  = rom_note;
               dur_d   = rom_dur;
               state_d = StLoad;
            end
         end
         StLoad:    state_d = StPlaying;
         StPlaying: begin
            if (bus_io.note_done) begin
               if (idx_q == '1) begin
                  end_of_song = 1'b1;
               end else begin
                  idx_d   = idx_q + IdxW'(1);
                  state_d = bus_io.play ? StFetch : StPaused;
               end
            end
         end
         default:   state_d = StPaused;
      endcase

      if (end_of_song) begin
         song_done_d = 1'b1;
`ifdef SONG_SEQ_LOOP_EN
         idx_d   = '0;
         state_d = bus_io.play ? StFetch : StPaused;
`else
         state_d = StPaused;
`endif
      end

      // A song switch overrides whatever the FSM decided this cycle.
      if (song_chg) begin
         cur_song_d  = bus_io.song;
         idx_d       = '0;
         song_done_d = 1'b0;
         note_d      = note_q;
         dur_d       = dur_q;
         state_d     = StPaused;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q     <= StPaused;
         idx_q       <= '0;
         cur_song_q  <= bus_io.song;
         note_q      <= '0;
         dur_q       <= '0;
         song_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cur_song_q  <= cur_song_d;
         note_q      <= note_d;
         dur_q       <= dur_d;
         song_done_q <= song_done_d;
      end
   end

   assign bus_io.note      = note_q;
   assign bus_io.duration  = dur_q;
   assign bus_io.new_note  = (state_q == StLoad) && !song_chg;
   assign bus_io.song_done = song_done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: cycle table for start-up, hand sequences for corners.
module tb_song_sequencer;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   song_sequencer_if bus ();

   song_sequencer dut (
      .clk_i    (clk),
      .reset_ni (rst_n),
      .bus_io   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst_n;
      logic       play;
      logic [1:0] song;
      logic       nd;
      logic       nn;
      logic [5:0] note;
      logic [5:0] dur;
      logic       sd;
   } vec_t;

   vec_t vecs [12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic wait_nn(input int budget, output int lat);
      lat = -1;
      for (int k = 1; k <= budget; k++) begin
         tick();
         if (bus.new_note === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   int lat;
   int cnt_nn;
   int cnt_sd_low;

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.play = 1'b1;
      bus.song = 2'd0;
      bus.note_done = 1'b0;

      // rst_n play song nd | new_note note dur song_done
      vecs[0]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0};
      vecs[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0};
      vecs[2]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0};
      vecs[3]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0};
      vecs[4]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 6'd12, 6'd10, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 6'd12, 6'd10, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 6'd12, 6'd10, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 6'd12, 6'd10, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 6'd20, 6'd5,  1'b0};
      vecs[9]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 6'd20, 6'd5,  1'b0};
      vecs[10] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 6'd20, 6'd5,  1'b0};
      vecs[11] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 6'd20, 6'd5,  1'b0};

      // Reset, first note and second note latency.
      for (int r = 0; r < 12; r++) begin
         rst_n         = vecs[r].rst_n;
         bus.play      = vecs[r].play;
         bus.song      = vecs[r].song;
         bus.note_done = vecs[r].nd;
         tick();
         check($sformatf("row%0d new_note", r), bus.new_note, vecs[r].nn);
         check($sformatf("row%0d note", r), bus.note, vecs[r].note);
         check($sformatf("row%0d duration", r), bus.duration, vecs[r].dur);
         check($sformatf("row%0d song_done", r), bus.song_done, vecs[r].sd);
      end

      // End marker at idx 2.
      tick();
      check("eos song_done", bus.song_done, 1);
      check("eos new_note", bus.new_note, 0);
      check("eos note held", bus.note, 20);
`ifdef SONG_SEQ_LOOP_EN
      tick();
      check("eos pulse fall", bus.song_done, 0);
`else
      cnt_nn = 0;
      cnt_sd_low = 0;
      repeat (20) begin
         tick();
         if (bus.new_note !== 1'b0) cnt_nn++;
         if (bus.song_done !== 1'b1) cnt_sd_low++;
      end
      check("eos play ignored new_note count", cnt_nn, 0);
      check("eos song_done drop count", cnt_sd_low, 0);
`endif

      // Song change clears song_done.
      bus.song = 2'd1;
      tick();
      check("chg song_done clear", bus.song_done, 0);
      check("chg new_note", bus.new_note, 0);

      // Mid-PLAYING song change 0 -> 1.
      rst_n = 1'b0;
      bus.song = 2'd0;
      tick();
      tick();
      rst_n = 1'b1;
      wait_nn(5, lat);
      check("restart latency", lat, 3);
      check("restart note", bus.note, 12);
      tick();
      bus.song = 2'd1;
      tick();
      check("midplay chg new_note", bus.new_note, 0);
      check("midplay chg song_done", bus.song_done, 0);
      wait_nn(5, lat);
      check("song1 latency", lat, 3);
      check("song1 note", bus.note, 33);
      check("song1 duration", bus.duration, 7);

      // Song change while in LOAD suppresses the pulse.
      bus.song = 2'd3;
      #1;
      check("load suppressed", bus.new_note, 0);
      tick();
      check("after suppress new_note", bus.new_note, 0);

      // Pause during PLAYING, then note_done.
      wait_nn(5, lat);
      check("song3 latency", lat, 3);
      check("song3 note", bus.note, 5);
      tick();
      bus.play = 1'b0;
      tick();
      check("pause in playing new_note", bus.new_note, 0);
      bus.note_done = 1'b1;
      tick();
      bus.note_done = 1'b0;
      tick();
      bus.note_done = 1'b1;
      tick();
      bus.note_done = 1'b0;
      cnt_nn = 0;
      repeat (4) begin
         tick();
         if (bus.new_note !== 1'b0) cnt_nn++;
      end
      check("paused no fetch count", cnt_nn, 0);
      bus.play = 1'b1;
      wait_nn(5, lat);
      check("resume latency", lat, 3);
      check("resume note", bus.note, 6);
      check("resume duration", bus.duration, 4);

      // Full 32-entry song ending by index wrap.
      tick();
      bus.song = 2'd2;
      tick();
      for (int i = 0; i < 32; i++) begin
         wait_nn(5, lat);
         check($sformatf("full%0d latency", i), lat, (i == 0) ? 3 : 2);
         check($sformatf("full%0d note", i), bus.note, 30 + i);
         check($sformatf("full%0d duration", i), bus.duration, i + 1);
         tick();
         bus.note_done = 1'b1;
         tick();
         bus.note_done = 1'b0;
      end
      check("wrap song_done", bus.song_done, 1);
`ifdef SONG_SEQ_LOOP_EN
      tick();
      check("wrap pulse fall", bus.song_done, 0);
      wait_nn(5, lat);
      check("loop latency", lat, 1);
      check("loop note", bus.note, 30);
`else
      cnt_nn = 0;
      cnt_sd_low = 0;
      repeat (10) begin
         tick();
         if (bus.new_note !== 1'b0) cnt_nn++;
         if (bus.song_done !== 1'b1) cnt_sd_low++;
      end
      check("wrap stop new_note count", cnt_nn, 0);
      check("wrap song_done drop count", cnt_sd_low, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
